led_bam_scheduler: RTL and testbench
====================================

Name: led_bam_scheduler

Overview:
- Parametrised BAM sequencer for HUB75-style LED panels. It drives row address, latch and OE, and handshakes with the AL422 shift stage.
- Generalises the fixed 8-scan / 3-plane controller to:
  - runtime scan depth, bit depth and brightness;
  - shift/display overlap: row n+1 shifts while row n is displayed;
  - a run-enable input.
- Sits between the AL422 shift stage (pixel/RGB/clock generation) and the panel control pins.

Parameters:
- ROW_BITS, 3, row address width; scan = 2^ROW_BITS (1..5).
- BAM_BITS, 8, bit planes per frame (1..16).
- BRIGHT_BITS, 8, width of brightness multiplier.
- OE_PREDELAY, 31, blanking cycles after latch before OE on (row-switch ghosting).
- OE_POSTDELAY, 31, blanking cycles after OE off before next latch allowed.
- LAT_ACTIVE_LOW, 0, invert led_lat_out.
- OE_ACTIVE_LOW, 1, invert led_oe_out.

Ports:
- in_clk  in  1  clock
- in_nrst  in  1  reset, asynchronous, active-low
- enable  in  1  run enable; 0 = stop after current OE window
- brightness  in  BRIGHT_BITS  OE on-time multiplier, sampled at frame start
- shift_busy  in  1  shift stage is clocking a row out
- shift_ready  in  1  shifted row waiting for latch (level)
- shift_start  out  1  one-cycle pulse: begin shifting next row
- shift_rewind  out  1  valid with shift_start: reset AL422 read address first
- shift_plane  out  clog2(BAM_BITS)  bit plane for the row being shifted
- shift_ack  out  1  one-cycle pulse: row latched, shift stage clears shift_ready
- led_row  out  ROW_BITS  panel row address
- led_lat_out  out  1  panel latch
- led_oe_out  out  1  panel output enable
- frame_start  out  1  one-cycle pulse on latch of row 0 / plane 0

Behaviour:
- Reset values:
  - shift_start, shift_rewind, shift_ack, frame_start = 0; shift_plane = 0.
  - led_row = all ones.
  - led_lat_out = LAT_ACTIVE_LOW; led_oe_out = OE_ACTIVE_LOW (both inactive).
  - Internal pointers: shift pointer = (row 0, plane 0); display plane = 0; timer IDLE; pending = 0; brightness latch = 0.
- Order:
  - Row is the inner index and plane the outer: row 0..2^ROW_BITS-1 for plane 0, then plane 1, and so on.
  - After plane BAM_BITS-1 / last row, wrap to (0,0).
- Shift request, pulsed 1 cycle when enable & !shift_busy & !shift_ready & !pending:
  - shift_plane = pointer plane;
  - shift_rewind = (pointer row == 0);
  - pending set. Pointer advances the same cycle.
- Latch, when shift_ready & timer IDLE & enable, registered:
  - led_lat active 1 cycle; shift_ack pulses the same cycle; pending cleared.
  - led_row takes the latched row the same edge.
  - Display plane = latched plane; timer starts.
  - The next shift_start is allowed the following cycle, overlapping OE.
- frame_start pulses with the latch of (row 0, plane 0). The brightness latch is loaded on that edge only; mid-frame brightness changes are ignored until the next frame.
- OE timer, states IDLE → PRE → ON → POST → IDLE:
  - PRE: OE_PREDELAY cycles, OE inactive.
  - ON: (brightness_latched+1) << plane cycles, OE active. Counter width BRIGHT_BITS+BAM_BITS, no overflow.
  - POST: OE_POSTDELAY cycles, OE inactive.
  - A delay of 0 skips that state.
  - OE is asserted only in ON and is never active in a latch cycle.
- Simultaneous events: shift_ready rising while timer in POST → latch on the first IDLE cycle. A latch and a shift request never coincide, because pending must clear first.
- enable=0:
  - No new shift_start and no new latch.
  - The running OE window completes.
  - A shift in progress completes and holds shift_ready.
  - Re-enable resumes from the held pointer.
- Reset mid-operation: all outputs go to reset values immediately, asynchronously, including OE inactive during ON.
- shift_ack without a latch is illegal and never generated. A shift_ready drop without shift_ack is ignored (no latch).

Decomposition:
- Shared package led_bam_pkg holds:
  - timer state enum (IDLE, PRE, ON, POST);
  - the clog2 helper;
  - scan/plane width constants shared with the shift stage.
- One sub-module, led_bam_oe_timer. Inputs: start, plane, brightness, parameters. Outputs: busy, oe.
- Pointer, handshake and latch logic stay in the top.

Test Plan:
- ROW_BITS=3, BAM_BITS=3, PRE=POST=2, brightness=0, shift model ready 5 cycles after shift_start → first shift_start has rewind=1, plane=0. Latch then yields led_row=0, frame_start=1, OE active exactly 1 cycle, starting 2 cycles after the latch cycle.
- brightness=3, plane 2 row → OE active exactly 16 consecutive cycles; timer busy 20 cycles.
- Overlap: shift_start for row 1 appears 1 cycle after the row-0 latch while OE is in PRE/ON. The next latch waits for timer IDLE even if shift_ready is already high.
- Wrap: 8 latches → plane 1 begins with shift_rewind=1. After 24 latches → pointer (0,0), frame_start pulses again; led_row sequence 0..7 each plane.
- Brightness 0→255 written mid-frame → ON lengths unchanged until the next frame_start, then (256<<plane).
- enable=0 during ON → OE window completes, no further latch or shift_start. Separately, in_nrst low during ON → led_oe_out inactive immediately, led_row=7.

Source files
------------

// File: rtl/led_bam_pkg.sv
// led_bam_pkg: shared timer states, width helpers and scan/plane limits
package led_bam_pkg;
  typedef enum logic [1:0] {T_IDLE, T_PRE, T_ON, T_POST} tmr_state_t;
  localparam int MAX_ROW_BITS = 5;
  localparam int MAX_BAM_BITS = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int plane_w(input int bam_bits);
    return (clog2(bam_bits) < 1) ? 1 : clog2(bam_bits);
  endfunction
endpackage

// File: rtl/led_bam_oe_timer.sv
// led_bam_oe_timer: PRE/ON/POST output-enable window started by each latch
module led_bam_oe_timer
  import led_bam_pkg::*;
#(
  parameter int BAM_BITS     = 8,
  parameter int BRIGHT_BITS  = 8,
  parameter int OE_PREDELAY  = 31,
  parameter int OE_POSTDELAY = 31,
  localparam int PW = plane_w(BAM_BITS),
  localparam int DW = clog2(((OE_PREDELAY > OE_POSTDELAY) ? OE_PREDELAY : OE_POSTDELAY) + 1),
  localparam int CW = (BRIGHT_BITS + BAM_BITS > DW) ? BRIGHT_BITS + BAM_BITS : DW
) (
  input  logic                   in_clk,
  input  logic                   in_nrst,
  input  logic                   i_start,
  input  logic [PW-1:0]          i_plane,
  input  logic [BRIGHT_BITS-1:0] i_bright,
  output logic                   o_busy,
  output logic                   o_oe
);
  localparam logic [CW-1:0] PRE_M1  = CW'(OE_PREDELAY - 1);
  localparam logic [CW-1:0] POST_M1 = CW'(OE_POSTDELAY - 1);
  tmr_state_t    r_st;
  logic [CW-1:0] r_cnt, r_on, w_on_m1;
  logic          r_oe;
  assign w_on_m1 = ((CW'(i_bright) + CW'(1)) << i_plane) - CW'(1);
  assign o_busy  = (r_st != T_IDLE);
  assign o_oe    = r_oe;
  // window sequencer; zero-length blanking phases are skipped entirely
  always_ff @(posedge in_clk or negedge in_nrst)
    if (!in_nrst) begin
      r_st  <= T_IDLE;
      r_cnt <= '0;
      r_on  <= '0;
      r_oe  <= 1'b0;
    end else begin
      case (r_st)
        T_IDLE: if (i_start) begin
          r_on <= w_on_m1;
          if (OE_PREDELAY > 0) begin
            r_st  <= T_PRE;
            r_cnt <= PRE_M1;
          end else begin
            r_st  <= T_ON;
            r_cnt <= w_on_m1;
            r_oe  <= 1'b1;
          end
        end
        T_PRE: if (r_cnt == '0) begin
          r_st  <= T_ON;
          r_cnt <= r_on;
          r_oe  <= 1'b1;
        end else r_cnt <= r_cnt - CW'(1);
        T_ON: if (r_cnt == '0) begin
          r_oe  <= 1'b0;
          r_st  <= (OE_POSTDELAY > 0) ? T_POST : T_IDLE;
          r_cnt <= POST_M1;
        end else r_cnt <= r_cnt - CW'(1);
        default: if (r_cnt == '0) r_st <= T_IDLE;
                 else r_cnt <= r_cnt - CW'(1);
      endcase
    end
endmodule

// File: rtl/led_bam_scheduler.sv
// led_bam_scheduler: BAM row/plane sequencer driving panel row, latch and OE
module led_bam_scheduler
  import led_bam_pkg::*;
#(
  parameter int ROW_BITS       = 3,
  parameter int BAM_BITS       = 8,
  parameter int BRIGHT_BITS    = 8,
  parameter int OE_PREDELAY    = 31,
  parameter int OE_POSTDELAY   = 31,
  parameter bit LAT_ACTIVE_LOW = 1'b0,
  parameter bit OE_ACTIVE_LOW  = 1'b1,
  localparam int PW = plane_w(BAM_BITS)
) (
  input  logic                   in_clk,
  input  logic                   in_nrst,
  input  logic                   enable,
  input  logic [BRIGHT_BITS-1:0] brightness,
  input  logic                   shift_busy,
  input  logic                   shift_ready,
  output logic                   shift_start,
  output logic                   shift_rewind,
  output logic [PW-1:0]          shift_plane,
  output logic                   shift_ack,
  output logic [ROW_BITS-1:0]    led_row,
  output logic                   led_lat_out,
  output logic                   led_oe_out,
  output logic                   frame_start
);
  logic [ROW_BITS-1:0]    r_ptr_row, r_sh_row, r_row;
  logic [PW-1:0]          r_ptr_plane, r_sh_plane, r_dplane;
  logic [BRIGHT_BITS-1:0] r_bright;
  logic                   r_pend, r_lat, r_start, r_rewind, r_frame;
  logic                   w_rdy, w_req, w_latch, w_first, w_busy, w_oe;
  // shift_ready is still high during the ack cycle; treat it as already cleared
  assign w_rdy   = shift_ready & ~r_lat;
  assign w_req   = enable & ~shift_busy & ~w_rdy & ~r_pend;
  assign w_latch = enable & w_rdy & ~w_busy;
  assign w_first = (r_sh_row == '0) && (r_sh_plane == '0);
  assign shift_start  = r_start;
  assign shift_rewind = r_rewind;
  assign shift_plane  = r_sh_plane;
  assign shift_ack    = r_lat;
  assign led_row      = r_row;
  assign frame_start  = r_frame;
  assign led_lat_out  = r_lat ^ LAT_ACTIVE_LOW;
  assign led_oe_out   = w_oe ^ OE_ACTIVE_LOW;
  // shift request: hand out the pointer position, then step row-inner/plane-outer
  always_ff @(posedge in_clk or negedge in_nrst)
    if (!in_nrst) begin
      r_ptr_row   <= '0;
      r_ptr_plane <= '0;
      r_sh_row    <= '0;
      r_sh_plane  <= '0;
      r_start     <= 1'b0;
      r_rewind    <= 1'b0;
    end else begin
      r_start  <= w_req;
      r_rewind <= w_req & (r_ptr_row == '0);
      if (w_req) begin
        r_sh_row   <= r_ptr_row;
        r_sh_plane <= r_ptr_plane;
        r_ptr_row  <= r_ptr_row + ROW_BITS'(1);
        if (&r_ptr_row)
          r_ptr_plane <= (r_ptr_plane == PW'(BAM_BITS - 1)) ? '0 : r_ptr_plane + PW'(1);
      end
    end
  // latch: pulse latch/ack, present the shifted row, load frame brightness on (0,0)
  always_ff @(posedge in_clk or negedge in_nrst)
    if (!in_nrst) begin
      r_pend   <= 1'b0;
      r_lat    <= 1'b0;
      r_frame  <= 1'b0;
      r_row    <= '1;
      r_dplane <= '0;
      r_bright <= '0;
    end else begin
      r_lat   <= w_latch;
      r_frame <= w_latch & w_first;
      r_pend  <= w_req | (r_pend & ~w_latch);
      if (w_latch) begin
        r_row    <= r_sh_row;
        r_dplane <= r_sh_plane;
      end
      if (w_latch & w_first) r_bright <= brightness;
    end
  led_bam_oe_timer #(
    .BAM_BITS    (BAM_BITS),
    .BRIGHT_BITS (BRIGHT_BITS),
    .OE_PREDELAY (OE_PREDELAY),
    .OE_POSTDELAY(OE_POSTDELAY)
  ) u_timer (
    .in_clk  (in_clk),
    .in_nrst (in_nrst),
    .i_start (r_lat),
    .i_plane (r_dplane),
    .i_bright(r_bright),
    .o_busy  (w_busy),
    .o_oe    (w_oe)
  );
endmodule

// File: tb/tb_led_bam_scheduler.sv
// tb_led_bam_scheduler: shift-stage model plus event-level BAM reference checks
module tb_led_bam_scheduler;
  localparam int RB = 3, BB = 3, BRB = 8, PRE = 2, POST = 2;
  localparam bit LAL = 1'b0, OAL = 1'b1;
  localparam int SCAN = 1 << RB, PL = BB;
  logic       in_clk = 0, in_nrst = 0, enable = 0, shift_busy = 0, shift_ready = 0;
  logic [7:0] brightness = 0;
  logic       shift_start, shift_rewind, shift_ack, led_lat_out, led_oe_out, frame_start;
  logic [1:0] shift_plane;
  logic [2:0] led_row;
  int checks = 0, errors = 0;
  int sd = 5, sh_cnt = 0;
  bit mon_en = 0;
  int cyc = 0, nl = 0, ns = 0, lat_cyc = 0, oe_end = 0, run = 0, cur_exp = 0, cur_plane = 0;
  int fb = 0, b_prev = 0, exp_lat = -1;
  bit prev_oe = 0, have_end = 0, lat, oe;
  int last_on [PL];
  typedef struct { int b; int on0; int on1; int on2; } vec_t;
  vec_t tbl [4];

  led_bam_scheduler #(
    .ROW_BITS(RB), .BAM_BITS(BB), .BRIGHT_BITS(BRB), .OE_PREDELAY(PRE), .OE_POSTDELAY(POST),
    .LAT_ACTIVE_LOW(LAL), .OE_ACTIVE_LOW(OAL)
  ) dut (
    .in_clk(in_clk), .in_nrst(in_nrst), .enable(enable), .brightness(brightness),
    .shift_busy(shift_busy), .shift_ready(shift_ready), .shift_start(shift_start),
    .shift_rewind(shift_rewind), .shift_plane(shift_plane), .shift_ack(shift_ack),
    .led_row(led_row), .led_lat_out(led_lat_out), .led_oe_out(led_oe_out),
    .frame_start(frame_start)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin tick(); n++; end while (!frame_start && n < 60000);
    chk("fs_wait", frame_start, 1);
  endtask

  task automatic wait_oe(input bit v, input int lim);
    int n = 0;
    do begin tick(); n++; end while (((led_oe_out ^ OAL) != v) && n < lim);
    chk("oe_wait", led_oe_out ^ OAL, v);
  endtask

  // shift-stage model (+1) and reference monitor (+2) each cycle
  initial forever begin
    @(posedge in_clk);
    #1;
    if (shift_ack) shift_ready = 0;
    if (sh_cnt > 0) begin
      sh_cnt--;
      if (sh_cnt == 0) begin shift_busy = 0; shift_ready = 1; end
    end
    if (shift_start) begin shift_busy = 1; sh_cnt = sd; end
    #1;
    if (mon_en) begin
      int r, p;
      lat = led_lat_out ^ LAL;
      oe  = led_oe_out ^ OAL;
      if (cyc == exp_lat) chk("post_latch", lat, 1);
      if (lat) begin
        r = nl % SCAN;
        p = (nl / SCAN) % PL;
        chk("lat_oe", oe, 0);
        chk("lat_row", led_row, r);
        chk("lat_ack", shift_ack, 1);
        chk("frame_start", frame_start, (r == 0 && p == 0));
        if (r == 0 && p == 0) fb = b_prev;
        cur_exp = (fb + 1) << p;
        cur_plane = p;
        lat_cyc = cyc;
        nl++;
      end else begin
        chk("stray_fs", frame_start, 0);
        chk("stray_ack", shift_ack, 0);
      end
      if (shift_start) begin
        r = ns % SCAN;
        p = (ns / SCAN) % PL;
        chk("sh_plane", shift_plane, p);
        chk("sh_rewind", shift_rewind, r == 0);
        if (ns > 0) chk("overlap", cyc - lat_cyc, 1);
        ns++;
      end
      if (oe && !prev_oe) begin chk("pre_gap", cyc - lat_cyc, PRE + 1); run = 0; end
      if (oe) run++;
      if (!oe && prev_oe) begin
        chk("on_len", run, cur_exp);
        last_on[cur_plane] = run;
        oe_end = cyc;
        have_end = 1;
      end
      if (have_end && cyc == oe_end + POST && shift_ready && enable && !lat) exp_lat = cyc + 1;
      prev_oe = oe;
      b_prev = brightness;
    end
    cyc++;
  end

  initial begin
    int nl0, ns0, hold;
    tbl[0] = '{255, 256, 512, 1024};
    tbl[1] = '{3, 4, 8, 16};
    tbl[2] = '{0, 1, 2, 4};
    tbl[3] = '{17, 18, 36, 72};
    repeat (3) @(posedge in_clk);
    #1;
    chk("rst_start", shift_start, 0);
    chk("rst_rewind", shift_rewind, 0);
    chk("rst_ack", shift_ack, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_plane", shift_plane, 0);
    chk("rst_row", led_row, 7);
    chk("rst_lat", led_lat_out, LAL);
    chk("rst_oe", led_oe_out, OAL);
    in_nrst = 1;
    mon_en = 1;
    tick();
    enable = 1;
    wait_fs();
    for (int i = 0; i < 4; i++) begin
      brightness = 8'(tbl[i].b);
      wait_fs();
      wait_fs();
      chk("tbl_on0", last_on[0], tbl[i].on0);
      chk("tbl_on1", last_on[1], tbl[i].on1);
      chk("tbl_on2", last_on[2], tbl[i].on2);
    end
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) brightness = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) sd = $urandom_range(1, 12);
      if (hold > 0) begin
        hold--;
        if (hold == 0) enable = 1;
      end else if ((led_oe_out ^ OAL) && $urandom_range(0, 29) == 0) begin
        enable = 0;
        hold = $urandom_range(1, 40);
      end
    end
    enable = 1;
    wait_oe(1, 3000);
    enable = 0;
    wait_oe(0, 3000);
    nl0 = nl;
    ns0 = ns;
    repeat (150) tick();
    chk("en_off_lat", nl - nl0, 0);
    chk("en_off_start", ns - ns0, 0);
    chk("en_off_ready_held", shift_ready, 1);
    enable = 1;
    repeat (3) tick();
    chk("resume_lat", nl - nl0, 1);
    mon_en = 0;
    wait_oe(1, 3000);
    #2 in_nrst = 0;
    #1;
    chk("midrst_oe", led_oe_out, OAL);
    chk("midrst_row", led_row, 7);
    chk("midrst_lat", led_lat_out, LAL);
    chk("midrst_start", shift_start, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
